// File: rtl/alu_operand_stage.sv
// ALU operand-select stage: forwards rs1/rs2, detects load-use hazards and
// presents A/B/store operands to EX through a one-deep valid/ready register.
module alu_operand_stage #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [WIDTH-1:0]  in_rs1_data,
    input  logic [WIDTH-1:0]  in_rs2_data,
    input  logic              in_rs2_used,
    input  logic [WIDTH-1:0]  in_imm,
    input  logic [WIDTH-1:0]  in_pc,
    input  logic [1:0]        in_a_sel,
    input  logic [1:0]        in_b_sel,
    input  logic              exm_wr_en,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [WIDTH-1:0]  exm_data,
    input  logic              exm_is_load,
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [WIDTH-1:0]  wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [WIDTH-1:0]  out_store_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] rs1_fwd, rs2_fwd;
    logic             hazard;
    logic             accept;

    // EX/MEM has priority over MEM/WB; x0 is never forwarded.
    always_comb begin
        rs1_fwd = in_rs1_data;
        if (exm_wr_en && (exm_rd == in_rs1_addr) && (in_rs1_addr != '0)) begin
            rs1_fwd = exm_data;
        end else if (wb_wr_en && (wb_rd == in_rs1_addr) && (in_rs1_addr != '0)) begin
            rs1_fwd = wb_data;
        end

        rs2_fwd = in_rs2_data;
        if (exm_wr_en && (exm_rd == in_rs2_addr) && (in_rs2_addr != '0)) begin
            rs2_fwd = exm_data;
        end else if (wb_wr_en && (wb_rd == in_rs2_addr) && (in_rs2_addr != '0)) begin
            rs2_fwd = wb_data;
        end
    end

    assign hazard = in_valid && exm_wr_en && exm_is_load && (exm_rd != '0) &&
                    (((in_a_sel == 2'd0) && (exm_rd == in_rs1_addr)) ||
                     (in_rs2_used && (exm_rd == in_rs2_addr)));

    assign in_ready = (!valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sd_d    = sd_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (accept) begin
            case (in_a_sel)
                2'd0:    a_d = rs1_fwd;
                2'd1:    a_d = in_pc;
                default: a_d = '0;
            endcase
            case (in_b_sel)
                2'd0:    b_d = rs2_fwd;
                2'd1:    b_d = in_imm;
                2'd2:    b_d = WIDTH'(4);
                default: b_d = '0;
            endcase
            sd_d = rs2_fwd;
        end

        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (hazard && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sd_q    <= sd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_a          = a_q;
    assign out_b          = b_q;
    assign out_store_data = sd_q;
    assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; a second instance with a 4-bit stall
// counter shares the stimulus to exercise saturation.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [4:0]  in_rs1_addr, in_rs2_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic        in_rs2_used;
    logic [1:0]  in_a_sel, in_b_sel;
    logic        exm_wr_en, exm_is_load, wb_wr_en;
    logic [4:0]  exm_rd, wb_rd;
    logic [31:0] exm_data, wb_data;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [31:0] out_a, out_b, out_store_data;
    logic [15:0] stall_cnt;

    logic        sat_in_ready, sat_out_valid;
    logic [31:0] sat_out_a, sat_out_b, sat_out_store_data;
    logic [3:0]  sat_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rs1_data(in_rs1_data),
        .in_rs2_data(in_rs2_data), .in_rs2_used(in_rs2_used), .in_imm(in_imm), .in_pc(in_pc),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .exm_wr_en(exm_wr_en), .exm_rd(exm_rd),
        .exm_data(exm_data), .exm_is_load(exm_is_load), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
        .out_b(out_b), .out_store_data(out_store_data), .stall_cnt(stall_cnt)
    );

    alu_operand_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rs1_data(in_rs1_data),
        .in_rs2_data(in_rs2_data), .in_rs2_used(in_rs2_used), .in_imm(in_imm), .in_pc(in_pc),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .exm_wr_en(exm_wr_en), .exm_rd(exm_rd),
        .exm_data(exm_data), .exm_is_load(exm_is_load), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_a(sat_out_a), .out_b(sat_out_b), .out_store_data(sat_out_store_data),
        .stall_cnt(sat_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] b_exp [4];

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_rs1_addr = '0; in_rs2_addr = '0; in_rs1_data = '0; in_rs2_data = '0;
        in_rs2_used = 1'b0; in_imm = '0; in_pc = '0; in_a_sel = '0; in_b_sel = '0;
        exm_wr_en = 1'b0; exm_rd = '0; exm_data = '0; exm_is_load = 1'b0;
        wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
        b_exp[0] = 32'd7; b_exp[1] = 32'hFFFF_FFF0; b_exp[2] = 32'd4; b_exp[3] = 32'd0;

        #12;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_a", out_a, 32'd0);
        check("reset_cnt", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Forwarding priority
        in_valid = 1'b1; in_rs1_addr = 5'd5; in_a_sel = 2'd0; in_rs1_data = 32'h1111_1111;
        in_b_sel = 2'd3; exm_wr_en = 1'b1; exm_rd = 5'd5; exm_data = 32'hAAAA_0000;
        wb_wr_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hBBBB_0000;
        #1 check("fwd_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("fwd_valid", {31'd0, out_valid}, 32'd1);
        check("fwd_exm", out_a, 32'hAAAA_0000);
        exm_wr_en = 1'b0;
        step();
        check("fwd_wb", out_a, 32'hBBBB_0000);
        exm_wr_en = 1'b1; in_rs1_addr = 5'd0; exm_rd = 5'd0; wb_rd = 5'd0;
        step();
        check("fwd_x0", out_a, 32'h1111_1111);
        in_a_sel = 2'd1; in_pc = 32'h100;
        step();
        check("a_pc", out_a, 32'h100);
        in_a_sel = 2'd2;
        step();
        check("a_zero", out_a, 32'd0);

        // B select
        exm_wr_en = 1'b0; wb_wr_en = 1'b0; in_rs2_addr = 5'd2; in_rs2_data = 32'd7;
        in_imm = 32'hFFFF_FFF0;
        for (int i = 0; i < 4; i++) begin
            in_b_sel = 2'(i);
            step();
            check($sformatf("b_sel%0d", i), out_b, b_exp[i]);
            check($sformatf("store%0d", i), out_store_data, 32'd7);
        end

        // Load-use hazard
        exm_wr_en = 1'b1; exm_is_load = 1'b1; exm_rd = 5'd3; exm_data = 32'hDEAD_BEEF;
        in_rs2_addr = 5'd3; in_rs2_used = 1'b1; in_rs1_addr = 5'd0; in_a_sel = 2'd0;
        in_b_sel = 2'd0; wb_wr_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        #1 check("lu_ready0", {31'd0, in_ready}, 32'd0);
        step();
        check("lu_ready1", {31'd0, in_ready}, 32'd0);
        check("lu_cnt1", {16'd0, stall_cnt}, 32'd1);
        check("lu_drain", {31'd0, out_valid}, 32'd0);
        step();
        check("lu_cnt2", {16'd0, stall_cnt}, 32'd2);
        exm_wr_en = 1'b0; exm_is_load = 1'b0;
        #1 check("lu_release", {31'd0, in_ready}, 32'd1);
        step();
        check("lu_b_wb", out_b, 32'h33);
        check("lu_store_wb", out_store_data, 32'h33);
        check("lu_cnt_hold", {16'd0, stall_cnt}, 32'd2);

        // Backpressure and flush
        out_ready = 1'b0; in_b_sel = 2'd1; wb_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready", {31'd0, in_ready}, 32'd0);
            step();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_b", out_b, 32'h33);
            check("bp_store", out_store_data, 32'h33);
        end
        flush = 1'b1;
        step();
        check("flush_hold", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        step();
        check("flush_accept", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;

        // Saturation: 20 hazard cycles
        exm_wr_en = 1'b1; exm_is_load = 1'b1; exm_rd = 5'd3;
        repeat (20) step();
        check("sat_cnt4", {28'd0, sat_stall_cnt}, 32'd15);
        check("sat_cnt16", {16'd0, stall_cnt}, 32'd22);

        // Asynchronous reset while holding a result
        exm_wr_en = 1'b0; exm_is_load = 1'b0; in_a_sel = 2'd1; in_pc = 32'h1234;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        step();
        check("pre_rst_a", out_a, 32'h1234);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_a", out_a, 32'd0);
        check("rst_b", out_b, 32'd0);
        check("rst_store", out_store_data, 32'd0);
        check("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst_cnt_sat", {28'd0, sat_stall_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
